// File: rtl/crc_checker_if.sv
// Serial CRC checker bus: payload/CRC bit streams in, frame verdict out.
interface crc_checker_if;
    logic       data;
    logic       active;
    logic       crc_in;
    logic       crc_valid;
    logic       busy;
    logic       done;
    logic       crc_ok;
    logic       crc_err;
    logic [7:0] err_cnt;

    modport master (
        output data, active, crc_in, crc_valid,
        input  busy, done, crc_ok, crc_err, err_cnt
    );

    modport slave (
        input  data, active, crc_in, crc_valid,
        output busy, done, crc_ok, crc_err, err_cnt
    );
endinterface

// File: rtl/crc_checker.sv
// Serial CRC checker: runs the payload through an LFSR, then compares the
// trailing CRC bits against the LFSR contents LSB-first and reports a verdict.
module crc_checker #(
    parameter int                    LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] SEEDS      = 8'b1101_1000,
    parameter logic [LFSR_WIDTH-1:0] TAPS       = 8'b0100_0100
) (
    input  logic         clk,
    input  logic         rst,
    crc_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

    localparam logic [3:0] LAST = 4'(LFSR_WIDTH - 1);

    state_t                state, state_nxt;
    logic [LFSR_WIDTH-1:0] lfsr, lfsr_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  mis, mis_nxt;
    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;
    logic                  ok_q, ok_nxt;
    logic                  err_q, err_nxt;
    logic [7:0]            ecnt_q, ecnt_nxt;
    logic                  take;
    logic                  bit_mis;
    logic [7:0]            ecnt_inc;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(
        input logic [LFSR_WIDTH-1:0] cur,
        input logic                  din
    );
        logic                  fb;
        logic [LFSR_WIDTH-1:0] nxt;
        fb = din ^ cur[0];
        nxt[LFSR_WIDTH-1] = fb;
        for (int i = 0; i < LFSR_WIDTH - 1; i++)
            nxt[i] = cur[i+1] ^ (TAPS[i] & fb);
        return nxt;
    endfunction

    assign bit_mis  = bus.crc_in ^ lfsr[0];
    assign ecnt_inc = (ecnt_q == 8'hFF) ? 8'hFF : ecnt_q + 8'd1;

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        cnt_nxt   = cnt;
        mis_nxt   = mis;
        done_nxt  = 1'b0;
        ok_nxt    = ok_q;
        err_nxt   = err_q;
        ecnt_nxt  = ecnt_q;
        take      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.active) begin
                    state_nxt = DATA;
                    lfsr_nxt  = lfsr_step(SEEDS, bus.data);
                    cnt_nxt   = '0;
                    mis_nxt   = 1'b0;
                    ok_nxt    = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            DATA: begin
                if (bus.active) begin
                    lfsr_nxt = lfsr_step(lfsr, bus.data);
                end else begin
                    state_nxt = CHECK;
                    take      = bus.crc_valid;
                end
            end
            CHECK: begin
                // Abort: report the broken frame and restart on this bit;
                // the error verdict stays visible through the new frame.
                if (bus.active) begin
                    done_nxt  = 1'b1;
                    ok_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    ecnt_nxt  = ecnt_inc;
                    state_nxt = DATA;
                    lfsr_nxt  = lfsr_step(SEEDS, bus.data);
                    cnt_nxt   = '0;
                    mis_nxt   = 1'b0;
                end else begin
                    take = bus.crc_valid;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (take) begin
            lfsr_nxt = lfsr >> 1;
            cnt_nxt  = cnt + 4'd1;
            mis_nxt  = mis | bit_mis;
            if (cnt == LAST) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                ok_nxt    = !(mis | bit_mis);
                err_nxt   = mis | bit_mis;
                if (mis | bit_mis)
                    ecnt_nxt = ecnt_inc;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            lfsr   <= SEEDS;
            cnt    <= '0;
            mis    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
            ecnt_q <= '0;
        end else begin
            state  <= state_nxt;
            lfsr   <= lfsr_nxt;
            cnt    <= cnt_nxt;
            mis    <= mis_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            ok_q   <= ok_nxt;
            err_q  <= err_nxt;
            ecnt_q <= ecnt_nxt;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.crc_ok  = ok_q;
    assign bus.crc_err = err_q;
    assign bus.err_cnt = ecnt_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: stimulus pushes expected frame verdicts,
// a monitor pops and compares them on every done pulse.
module tb_crc_checker;

    typedef struct packed {
        logic       ok;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    crc_checker_if bus();

    crc_checker dut (.clk(clk), .rst(rst), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    logic [7:0] exp_cnt = 8'd0;

    localparam logic [7:0] PAYLOAD  = 8'hA5;
    localparam logic [7:0] CRC_GOOD = 8'h7D;
    localparam logic [7:0] CRC_BAD  = 8'h7C;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are applied 1 time unit after the rising edge.
    task automatic drive(input logic d, input logic a, input logic ci, input logic cv);
        bus.data      = d;
        bus.active    = a;
        bus.crc_in    = ci;
        bus.crc_valid = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) drive(b[i], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_crc(input logic [7:0] c, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, 1'b0, c[i], 1'b1);
            if (i < nbits - 1) begin
                for (int g = 0; g < gap; g++) begin
                    drive(1'b0, 1'b0, 1'b1, 1'b0);
                    chk("busy_in_gap", 32'(bus.busy), 32'd1);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_frame(input logic ok);
        exp_t e;
        if (!ok) exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
        e.ok  = ok;
        e.err = !ok;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"},    32'(bus.busy),    32'd0);
        chk({name, "_done"},    32'(bus.done),    32'd0);
        chk({name, "_ok"},      32'(bus.crc_ok),  32'd0);
        chk({name, "_err"},     32'(bus.crc_err), 32'd0);
        chk({name, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding verdict.
    always @(negedge clk) begin
        if (rst && bus.done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no verdict pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("verdict_ok",      32'(bus.crc_ok),  32'(e.ok));
                chk("verdict_err",     32'(bus.crc_err), 32'(e.err));
                chk("verdict_err_cnt", 32'(bus.err_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.data = 1'b0; bus.active = 1'b0; bus.crc_in = 1'b0; bus.crc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        idle(2);

        // crc_valid in IDLE is ignored
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk_all_zero("idle_crc_valid");

        // good frame
        expect_frame(1'b1);
        send_byte(PAYLOAD);
        chk("busy_in_data", 32'(bus.busy), 32'd1);
        send_crc(CRC_GOOD, 8, 0);
        idle(3);
        chk("busy_after_frame", 32'(bus.busy), 32'd0);

        // bad frame
        expect_frame(1'b0);
        send_byte(PAYLOAD);
        send_crc(CRC_BAD, 8, 0);
        idle(3);

        // good frame with 3-cycle gaps between CRC bits
        expect_frame(1'b1);
        send_byte(PAYLOAD);
        send_crc(CRC_GOOD, 8, 3);
        idle(3);

        // abort after 4 CRC bits, then a good frame started by the abort bit
        expect_frame(1'b0);
        expect_frame(1'b1);
        send_byte(PAYLOAD);
        send_crc(CRC_GOOD, 4, 0);
        send_byte(PAYLOAD);
        chk("err_held_after_abort", 32'(bus.crc_err), 32'd1);
        send_crc(CRC_GOOD, 8, 0);
        idle(3);

        // 256 back-to-back bad frames: err_cnt must saturate
        for (int f = 0; f < 256; f++) begin
            expect_frame(1'b0);
            send_byte(PAYLOAD);
            send_crc(CRC_BAD, 8, 0);
        end
        idle(3);
        chk("err_cnt_saturated", 32'(bus.err_cnt), 32'hFF);

        // reset during CHECK: everything clears, no verdict
        send_byte(PAYLOAD);
        send_crc(CRC_GOOD, 4, 0);
        bus.crc_valid = 1'b0;
        rst = 1'b0;
        #2;
        chk_all_zero("reset_in_check");
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_cnt = 8'd0;
        idle(3);
        chk_all_zero("after_reset_idle");

        // normal operation resumes
        expect_frame(1'b1);
        send_byte(PAYLOAD);
        send_crc(CRC_GOOD, 8, 0);
        idle(4);

        chk("pending_verdicts", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_checker.md
CRC_CHECKER -- requirements
Module: crc_checker

Interface
REQ-001 SHALL have parameter LFSR_WIDTH, default 8, CRC/LFSR width in bits.
REQ-002 SHALL have parameter SEEDS, default 8'b1101_1000, LFSR reset/frame-start value.
REQ-003 SHALL have parameter TAPS, default 8'b0100_0100, XOR-tap mask on LFSR bits [LFSR_WIDTH-2:0].
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data  input  1  serial payload bit, sampled when active=1.
REQ-007 SHALL have port active  input  1  payload phase qualifier.
REQ-008 SHALL have port crc_in  input  1  serial received CRC bit, LSB (lfsr[0]) first.
REQ-009 SHALL have port crc_valid  input  1  crc_in qualifier.
REQ-010 SHALL have port busy  output  1  high while state is DATA or CHECK.
REQ-011 SHALL have port done  output  1  one-cycle pulse, frame verdict available.
REQ-012 SHALL have port crc_ok  output  1  last frame passed, held until next frame start.
REQ-013 SHALL have port crc_err  output  1  last frame failed or aborted, held until next frame start.
REQ-014 SHALL have port err_cnt  output  8  saturating count of failed/aborted frames.

Function
REQ-015 SHALL implement states IDLE, DATA, CHECK; all outputs registered.
REQ-016 SHALL step the LFSR per payload bit: fb = data ^ lfsr[0]; lfsr[MSB] <= fb; for i = MSB-1..0, lfsr[i] <= fb ^ lfsr[i+1] if TAPS[i], else lfsr[i+1].
REQ-017 IDLE: active=1 -> DATA; the LFSR steps from SEEDS with that bit in the same cycle; crc_ok, crc_err cleared; bit counter cleared.
REQ-018 IDLE: crc_valid=1 while active=0 SHALL be ignored, with no state or output change.
REQ-019 DATA: active=1 -> step the LFSR and stay in DATA; active=0 -> CHECK.
REQ-020 DATA: if active=0 and crc_valid=1 in the same cycle, that crc_in bit SHALL be consumed as CRC bit 0.
REQ-021 DATA: if active=1 and crc_valid=1 in the same cycle, active wins and crc_valid is ignored.
REQ-022 CHECK, per crc_valid=1 cycle:
- compare crc_in with lfsr[0];
- OR any mismatch into a sticky flag;
- shift lfsr right by one (MSB filled with 0);
- increment the 4-bit bit counter.
REQ-023 CHECK: crc_valid=0 SHALL hold all state (gaps allowed, no timeout).
REQ-024 On the LFSR_WIDTH-th CRC bit, the next cycle SHALL show:
- done=1;
- crc_ok = !mismatch, crc_err = mismatch (the final bit's comparison included);
- err_cnt incremented if crc_err, saturating at 8'hFF;
- state IDLE.
REQ-025 CHECK with active=1 before all CRC bits are received = abort; the next cycle SHALL show:
- done=1, crc_err=1, crc_ok=0, err_cnt incremented;
- the active bit starts a new frame (LFSR from SEEDS stepped, state DATA);
- crc_err is not cleared by this frame start.
REQ-026 active=1 in the cycle done is high SHALL start a new frame normally per REQ-017.
REQ-027 done SHALL be high exactly one cycle per completed or aborted frame.

Reset
REQ-028 rst=0 SHALL asynchronously force:
- state IDLE, lfsr=SEEDS;
- bit counter 0, mismatch flag 0;
- busy, done, crc_ok, crc_err = 0;
- err_cnt = 0.
REQ-029 Reset mid-frame SHALL discard the frame with no done pulse; operation resumes on the first clk edge after rst=1.

Verification
REQ-030 Payload 8'hA5 sent LSB-first (1,0,1,0,0,1,0,1), then CRC bits 1,0,1,1,1,1,1,0 (0x7D LSB-first) -> done=1, crc_ok=1, crc_err=0, err_cnt=0.
REQ-031 Same payload with CRC 0x7C -> done=1, crc_ok=0, crc_err=1, err_cnt=1.
REQ-032 Same as REQ-030 with crc_valid gaps of 3 cycles between CRC bits -> identical pass result, busy=1 throughout the gaps.
REQ-033 Abort:
- stimulus: 0xA5, 4 CRC bits, then active=1 with a new 0xA5 frame and correct CRC;
- response: first done has crc_err=1, second done has crc_ok=1, err_cnt=1.
REQ-034 Other cases:
- 256 consecutive bad frames -> err_cnt=8'hFF, not wrapped;
- rst=0 during CHECK -> all outputs 0, no done pulse;
- crc_valid pulses in IDLE -> no effect.
